// File: rtl/port_resp_arb.sv
// Output-port request/response arbiter: round-robin grant of one input channel, then re-framing
// of that channel's packet toward the packet-memory writer while tracking free RAM blocks.
module port_resp_arb #(
  parameter int unsigned          PORTNUM   = 16,
  parameter int unsigned          DWIDTH    = 32,
  parameter int unsigned          RAMWIDTH  = 11,
  parameter logic [RAMWIDTH-1:0]  RAMBLOCKS = 11'd1024,
  parameter int unsigned          TIMEOUT   = 16,
  localparam int unsigned         SrcW      = $clog2(PORTNUM)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PORTNUM-1:0]  i_req,
  input  logic [PORTNUM-1:0]  i_sop,
  input  logic [DWIDTH-1:0]   i_data [PORTNUM-1:0],
  input  logic [PORTNUM-1:0]  i_data_vld,
  input  logic                i_free,
  input  logic [RAMWIDTH-1:0] i_free_blocks,
  output logic [PORTNUM-1:0]  o_resp,
  output logic [PORTNUM-1:0]  o_nresp,
  output logic                o_ready,
  output logic [RAMWIDTH-1:0] o_ramspace,
  output logic                o_sop,
  output logic                o_eop,
  output logic                o_data_vld,
  output logic [DWIDTH-1:0]   o_data,
  output logic [SrcW-1:0]     o_src,
  output logic                o_err
);

  localparam int unsigned BeatW = 10;
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
  localparam int unsigned SumW  = RAMWIDTH + 2;

  typedef enum logic [1:0] {StIdle, StWaitSop, StRecv} state_e;

  state_e               state_q, state_d;
  logic [SrcW-1:0]      gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]     beat_cnt_q, beat_cnt_d, need_beats_q, need_beats_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic [RAMWIDTH-1:0]  ramspace_q, ramspace_d;
  logic [PORTNUM-1:0]   resp_q, resp_d, nresp_q, nresp_d;
  logic                 ready_q, ready_d, sop_q, sop_d, eop_q, eop_d, vld_q, vld_d, err_q, err_d;
  logic [DWIDTH-1:0]    data_q, data_d;
  logic [SrcW-1:0]      src_q, src_d;

  logic [SrcW-1:0]      pick, scan_idx;
  logic                 pick_vld;
  logic [10:0]          len_ext;
  logic [BeatW-1:0]     hdr_need, last_need;
  logic [RAMWIDTH:0]    hdr_blocks, blk_sub;
  logic [RAMWIDTH-1:0]  free_add;
  logic [SumW-1:0]      space_sum;
  logic                 hdr_fire, timeout, underflow, overflow;

  // First requester at or above rr_ptr, wrapping (PORTNUM is a power of 2).
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < PORTNUM; i++) begin
      scan_idx = rr_ptr_q + SrcW'(i);
      if (!pick_vld && i_req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Header length L lives in bits [16:7]; beats = 1 + ceil((L+1)/4), blocks = ceil((L+5)/64).
  always_comb begin
    len_ext    = {1'b0, i_data[gnt_q][16:7]};
    hdr_need   = BeatW'((len_ext + 11'd4) >> 2) + BeatW'(1);
    hdr_blocks = (RAMWIDTH+1)'((len_ext + 11'd68) >> 6);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    need_beats_d = need_beats_q;
    to_cnt_d     = to_cnt_q;
    resp_d       = '0;
    nresp_d      = '0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    vld_d        = 1'b0;
    data_d       = data_q;
    src_d        = src_q;
    timeout      = 1'b0;
    hdr_fire     = 1'b0;
    last_need    = need_beats_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          resp_d[pick]  = 1'b1;
          nresp_d       = i_req;
          nresp_d[pick] = 1'b0;
          gnt_d         = pick;
          rr_ptr_d      = pick + SrcW'(1);
          to_cnt_d      = '0;
          state_d       = StWaitSop;
        end
      end
      StWaitSop: begin
        nresp_d = i_req;
        if (i_sop[gnt_q]) begin
          beat_cnt_d = '0;
          state_d    = StRecv;
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StRecv: begin
        nresp_d = i_req;
        if (i_data_vld[gnt_q]) begin
          vld_d      = 1'b1;
          data_d     = i_data[gnt_q];
          src_d      = gnt_q;
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_cnt_q == '0) begin
            hdr_fire     = 1'b1;
            sop_d        = 1'b1;
            need_beats_d = hdr_need;
            last_need    = hdr_need;
          end
          if (beat_cnt_d == last_need) begin
            eop_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-block accounting in a wider signed-by-MSB sum so both clamp directions are visible.
  always_comb begin
    free_add   = i_free ? i_free_blocks : '0;
    blk_sub    = hdr_fire ? hdr_blocks : '0;
    space_sum  = SumW'(ramspace_q) + SumW'(free_add) - SumW'(blk_sub);
    underflow  = space_sum[SumW-1];
    overflow   = !underflow && (space_sum > SumW'(RAMBLOCKS));
    if (underflow) begin
      ramspace_d = '0;
    end else if (overflow) begin
      ramspace_d = RAMBLOCKS;
    end else begin
      ramspace_d = space_sum[RAMWIDTH-1:0];
    end
    err_d   = timeout | underflow | overflow;
    ready_d = (state_q == StIdle) && !(|i_req) && (ramspace_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      need_beats_q <= '0;
      to_cnt_q     <= '0;
      ramspace_q   <= RAMBLOCKS;
      resp_q       <= '0;
      nresp_q      <= '0;
      ready_q      <= 1'b1;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      vld_q        <= 1'b0;
      data_q       <= '0;
      src_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      need_beats_q <= need_beats_d;
      to_cnt_q     <= to_cnt_d;
      ramspace_q   <= ramspace_d;
      resp_q       <= resp_d;
      nresp_q      <= nresp_d;
      ready_q      <= ready_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      vld_q        <= vld_d;
      data_q       <= data_d;
      src_q        <= src_d;
      err_q        <= err_d;
    end
  end

  assign o_resp     = resp_q;
  assign o_nresp    = nresp_q;
  assign o_ready    = ready_q;
  assign o_ramspace = ramspace_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_data_vld = vld_q;
  assign o_data     = data_q;
  assign o_src      = src_q;
  assign o_err      = err_q;

endmodule

// File: doc/port_resp_arb.md
# port_resp_arb

Output-port side of the channel request/response handshake: one instance per output port, facing all PORTNUM input channel requesters. It arbitrates concurrent one-cycle requests round-robin and answers the winner with `o_resp` and every loser with `o_nresp`. It then captures the granted channel's sop/data/eop stream, re-frames it toward the port's packet-memory writer, and maintains the free-block count and ready flag that requesters use to qualify their requests.

## Interface
- PORTNUM, 16, number of input channels (power of 2).
- DWIDTH, 32, data word width.
- RAMWIDTH, 11, width of free-block count.
- RAMBLOCKS, 11'd1024, free 64-byte blocks after reset.
- TIMEOUT, 16, cycles allowed between resp and granted sop.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  PORTNUM  bit c = one-cycle request pulse from channel c.
- i_sop  in  PORTNUM  per-channel start-of-packet pulse.
- i_data  in  DWIDTH x PORTNUM (unpacked [PORTNUM-1:0])  per-channel data.
- i_data_vld  in  PORTNUM  per-channel beat valid.
- i_free  in  1  block release pulse from memory reader.
- i_free_blocks  in  RAMWIDTH  blocks released with i_free.
- o_resp  out  PORTNUM  one-hot grant pulse.
- o_nresp  out  PORTNUM  reject pulse, one bit per rejected requester.
- o_ready  out  1  port accepting requests.
- o_ramspace  out  RAMWIDTH  current free blocks.
- o_sop, o_eop, o_data_vld  out  1  re-framed stream flags.
- o_data  out  DWIDTH  re-framed data.
- o_src  out  $clog2(PORTNUM)  source channel of current packet.
- o_err  out  1  one-cycle error pulse.

## Operation
- States: IDLE, WAIT_SOP, RECV. Registers: gnt (source index), rr_ptr, beat_cnt, need_beats, to_cnt, ramspace.
- IDLE, any i_req bit set: pick first set bit scanning from rr_ptr upward modulo PORTNUM.
  - o_resp[g] pulses; o_nresp pulses for all other set bits.
  - gnt := g; rr_ptr := g+1 mod PORTNUM; go WAIT_SOP.
- WAIT_SOP:
  - Any i_req bit -> o_nresp on that bit next cycle, no state change. This also applies in RECV.
  - i_sop[gnt] -> RECV.
  - to_cnt reaches TIMEOUT first -> pulse o_err, go IDLE. No ramspace change.
- RECV: only channel gnt is observed; other channels' sop/vld are ignored.
  - First i_data_vld[gnt] beat is the header. L = i_data[gnt][16:7] (10 bit).
  - need_beats = 1 + ceil((L+1)/4): header plus payload words.
  - blocks = ceil((L+5)/64), computed in RAMWIDTH+1 bits.
  - ramspace -= blocks at the header beat.
  - On the beat where beat_cnt reaches need_beats: go IDLE. Framing is by count only; requester eop timing is not used.
- ramspace update each cycle: next = ramspace - (header ? blocks : 0) + (i_free ? i_free_blocks : 0).
  - Clamp to [0, RAMBLOCKS].
  - Underflow or overflow sets the clamped value and pulses o_err.
- o_ready = (state==IDLE) && ramspace!=0, registered.

## Timing
- Reset values:
  - o_resp, o_nresp, o_sop, o_eop, o_data_vld, o_data, o_src, o_err: 0.
  - o_ready: 1.
  - o_ramspace: RAMBLOCKS.
  - rr_ptr 0; state IDLE.
- Request at cycle t (IDLE) -> o_resp/o_nresp high for exactly cycle t+1. o_ready low from t+1.
- The requester pulses sop one cycle after seeing resp; the header beat follows one cycle after sop. Beats may be gapped; vld low does not advance beat_cnt.
- Stream latency is 1 cycle: beat at t -> o_data/o_data_vld/o_src at t+1.
  - o_sop is asserted with the header beat's o_data_vld.
  - o_eop is asserted with the last beat's o_data_vld.
- o_ramspace reflects the header decrement at header+1. o_ready returns 1 the cycle after the last beat is output, if ramspace!=0.
- Request in the same cycle the FSM enters IDLE (last beat) is nresp'd. Requests are sampled only while registered state is IDLE.
- Reset mid-packet: all state cleared immediately. A partial packet is dropped with no o_eop, and blocks are not restored.

## Test plan
- Single request: i_req=16'h0004 in IDLE -> o_resp=16'h0004 one cycle later, o_nresp=0, o_ready=0. Then sop, then header L=0 plus 1 payload word -> 2 output beats with o_sop on beat 1 and o_eop on beat 2, o_src=2. o_ramspace 1024->1023.
- Contention and round-robin: i_req=16'h8011 with rr_ptr=0 -> resp bit 0, nresp=16'h8010. Repeat the same i_req after the packet -> resp bit 4, nresp=16'h8001.
- Busy reject: i_req=16'h0100 while in RECV -> o_nresp=16'h0100 next cycle, packet unaffected.
- Long packet with gaps: L=63 with vld toggling 1/0 -> 17 output beats, o_eop only on the 17th, ramspace -2.
- Simultaneous free and header: ramspace=1, header L=63, i_free=1, i_free_blocks=3 in the same cycle -> ramspace=2, no o_err. Separately, ramspace=1 with an L=63 header alone -> ramspace=0, o_err pulse, o_ready stays 0.
- Sop timeout: resp issued, no i_sop for 16 cycles -> o_err pulse, return to IDLE, o_ready=1, ramspace unchanged. Separately, async reset asserted mid-RECV -> all outputs at reset values within the same cycle.
